icache_fetch_rob: RTL and testbench

ICACHE_FETCH_ROB -- requirements
Module: icache_fetch_rob

---
 rtl/toy_pack.sv | 33 +++
 rtl/icache_fetch_rob.sv | 150 +++++++++++++++
 tb/tb_icache_fetch_rob.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toy_pack.sv
// Shared types and sizing for the in-order instruction fetch reorder buffer.
package toy_pack;

    localparam int unsigned ICACHE_REQ_TXNID_WIDTH     = 4;
    localparam int unsigned ICACHE_UPSTREAM_DATA_WIDTH = 64;
    localparam int unsigned REQ_ADDR_WIDTH             = 32;
    localparam int unsigned UPSTREAM_OPCODE_WIDTH      = 4;

    // Must be a power of two and fit in the txnid space.
    localparam int unsigned FETCH_ROB_DEPTH     = 8;
    localparam int unsigned FETCH_ROB_PTR_WIDTH = $clog2(FETCH_ROB_DEPTH);

    localparam logic [UPSTREAM_OPCODE_WIDTH-1:0] UPSTREAM_OPCODE = 4'h4;

    typedef logic [REQ_ADDR_WIDTH-1:0] req_addr_t;

    // Request payload towards the icache rxreq channel.
    typedef struct packed {
        req_addr_t                         addr;
        logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
        logic [UPSTREAM_OPCODE_WIDTH-1:0]  opcode;
    } pc_req_t;

    // Payload held per rob slot; control flags live in separate vectors.
    typedef struct packed {
        req_addr_t                             addr;
        logic [ICACHE_UPSTREAM_DATA_WIDTH-1:0] data;
    } rob_entry_t;

    // Pointer with one extra wrap bit above the slot index.
    typedef logic [FETCH_ROB_PTR_WIDTH:0] rob_ptr_t;

endpackage

// File: rtl/icache_fetch_rob.sv
// Fetch reorder buffer: tags icache requests with the rob slot index, accepts
// out-of-order line returns and hands lines to decode in request order.
// Flush turns in-flight slots into zombies whose late returns are swallowed.
module icache_fetch_rob
    import toy_pack::*;
(
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  fetch_req_vld,
    output logic                                  fetch_req_rdy,
    input  req_addr_t                             fetch_req_addr,
    output logic                                  icache_req_vld,
    input  logic                                  icache_req_rdy,
    output pc_req_t                               icache_req_pld,
    input  logic                                  icache_rsp_vld,
    input  logic [ICACHE_UPSTREAM_DATA_WIDTH-1:0] icache_rsp_data,
    input  logic [ICACHE_REQ_TXNID_WIDTH-1:0]     icache_rsp_txnid,
    output logic                                  fetch_rsp_vld,
    input  logic                                  fetch_rsp_rdy,
    output logic [ICACHE_UPSTREAM_DATA_WIDTH-1:0] fetch_rsp_data,
    output req_addr_t                             fetch_rsp_addr,
    output logic [FETCH_ROB_PTR_WIDTH:0]          rob_cnt,
    output logic                                  rsp_err
);

    localparam int unsigned DEPTH = FETCH_ROB_DEPTH;
    localparam int unsigned PTR_W = FETCH_ROB_PTR_WIDTH;
    localparam int unsigned TID_W = ICACHE_REQ_TXNID_WIDTH;

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH > (1 << TID_W)) begin : g_depth_chk
        $error("FETCH_ROB_DEPTH must be a power of two within the txnid space");
    end

    rob_ptr_t         r_head;
    rob_ptr_t         r_tail;
    logic [DEPTH-1:0] r_alloc;
    logic [DEPTH-1:0] r_done;
    logic [DEPTH-1:0] r_zombie;
    logic             r_rsp_err;
    rob_entry_t       r_entry [DEPTH];

    logic [PTR_W-1:0] w_head_idx;
    logic [PTR_W-1:0] w_tail_idx;
    logic [PTR_W-1:0] w_rsp_idx;
    logic             w_full;
    logic             w_tail_free;
    logic             w_fire;
    logic             w_drain;
    logic             w_rsp_in_range;
    logic             w_rsp_hit;
    logic             w_rsp_zombie;
    logic             w_rsp_bad;
    logic [DEPTH-1:0] w_alloc_nxt;
    logic [DEPTH-1:0] w_done_nxt;
    logic [DEPTH-1:0] w_zombie_nxt;
    logic             w_rsp_err_nxt;

    assign w_head_idx = r_head[PTR_W-1:0];
    assign w_tail_idx = r_tail[PTR_W-1:0];
    assign rob_cnt    = r_tail - r_head;
    assign w_full     = (rob_cnt == (PTR_W+1)'(DEPTH));

    // Tail slot can take a new fetch: not full, not awaiting a zombie return, not flushing.
    assign w_tail_free    = rst_n && !w_full && !r_zombie[w_tail_idx] && !flush;
    assign fetch_req_rdy  = icache_req_rdy && w_tail_free;
    assign icache_req_vld = fetch_req_vld && w_tail_free;
    assign w_fire         = fetch_req_vld && fetch_req_rdy;
    assign icache_req_pld = pc_req_t'{addr:   fetch_req_addr,
                                      txnid:  TID_W'(w_tail_idx),
                                      opcode: UPSTREAM_OPCODE};

    // Output only from registered slot state; a return is visible the cycle after it lands.
    assign fetch_rsp_vld  = r_alloc[w_head_idx] && r_done[w_head_idx] && !flush;
    assign fetch_rsp_data = r_entry[w_head_idx].data;
    assign fetch_rsp_addr = r_entry[w_head_idx].addr;
    assign w_drain        = fetch_rsp_vld && fetch_rsp_rdy;
    assign rsp_err        = r_rsp_err;

    // Classify the incoming icache return against the slot it names.
    assign w_rsp_in_range = ((TID_W+1)'(icache_rsp_txnid) < (TID_W+1)'(DEPTH));
    assign w_rsp_idx      = icache_rsp_txnid[PTR_W-1:0];
    assign w_rsp_hit      = icache_rsp_vld && w_rsp_in_range &&
                            r_alloc[w_rsp_idx] && !r_done[w_rsp_idx];
    assign w_rsp_zombie   = icache_rsp_vld && w_rsp_in_range && r_zombie[w_rsp_idx];
    assign w_rsp_bad      = icache_rsp_vld && !w_rsp_hit && !w_rsp_zombie;

    // Next-state of the per-slot flags: return, drain and alloc combine; flush overrides.
    always_comb begin
        w_alloc_nxt   = r_alloc;
        w_done_nxt    = r_done;
        w_zombie_nxt  = r_zombie;
        w_rsp_err_nxt = r_rsp_err || w_rsp_bad;
        if (w_rsp_zombie) begin
            w_zombie_nxt[w_rsp_idx] = 1'b0;
        end
        if (flush) begin
            // In-flight slots go zombie unless their line is landing right now.
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (r_alloc[i] && !r_done[i] && !(w_rsp_hit && w_rsp_idx == PTR_W'(i))) begin
                    w_zombie_nxt[i] = 1'b1;
                end
            end
            w_alloc_nxt = '0;
            w_done_nxt  = '0;
        end else begin
            if (w_rsp_hit) begin
                w_done_nxt[w_rsp_idx] = 1'b1;
            end
            if (w_drain) begin
                w_alloc_nxt[w_head_idx] = 1'b0;
                w_done_nxt[w_head_idx]  = 1'b0;
            end
            if (w_fire) begin
                w_alloc_nxt[w_tail_idx] = 1'b1;
                w_done_nxt[w_tail_idx]  = 1'b0;
            end
        end
    end

    // Pointer and flag registers; flush snaps head onto tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_alloc   <= '0;
            r_done    <= '0;
            r_zombie  <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_tail    <= r_tail + (PTR_W+1)'(w_fire);
            r_head    <= flush ? r_tail : r_head + (PTR_W+1)'(w_drain);
            r_alloc   <= w_alloc_nxt;
            r_done    <= w_done_nxt;
            r_zombie  <= w_zombie_nxt;
            r_rsp_err <= w_rsp_err_nxt;
        end
    end

    // Payload flops, deliberately unreset: address on alloc, line data on a live return.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_entry[w_tail_idx].addr <= fetch_req_addr;
        end
        if (w_rsp_hit && !flush) begin
            r_entry[w_rsp_idx].data <= icache_rsp_data;
        end
    end

endmodule

// File: tb/tb_icache_fetch_rob.sv
// Bench for icache_fetch_rob: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_icache_fetch_rob;
    import toy_pack::*;

    localparam int unsigned D  = FETCH_ROB_DEPTH;
    localparam int unsigned DW = ICACHE_UPSTREAM_DATA_WIDTH;
    localparam int unsigned TW = ICACHE_REQ_TXNID_WIDTH;
    localparam int unsigned PW = FETCH_ROB_PTR_WIDTH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              fetch_req_vld;
    logic              fetch_req_rdy;
    req_addr_t         fetch_req_addr;
    logic              icache_req_vld;
    logic              icache_req_rdy;
    pc_req_t           icache_req_pld;
    logic              icache_rsp_vld;
    logic [DW-1:0]     icache_rsp_data;
    logic [TW-1:0]     icache_rsp_txnid;
    logic              fetch_rsp_vld;
    logic              fetch_rsp_rdy;
    logic [DW-1:0]     fetch_rsp_data;
    req_addr_t         fetch_rsp_addr;
    logic [PW:0]       rob_cnt;
    logic              rsp_err;

    icache_fetch_rob u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .fetch_req_vld    (fetch_req_vld),
        .fetch_req_rdy    (fetch_req_rdy),
        .fetch_req_addr   (fetch_req_addr),
        .icache_req_vld   (icache_req_vld),
        .icache_req_rdy   (icache_req_rdy),
        .icache_req_pld   (icache_req_pld),
        .icache_rsp_vld   (icache_rsp_vld),
        .icache_rsp_data  (icache_rsp_data),
        .icache_rsp_txnid (icache_rsp_txnid),
        .fetch_rsp_vld    (fetch_rsp_vld),
        .fetch_rsp_rdy    (fetch_rsp_rdy),
        .fetch_rsp_data   (fetch_rsp_data),
        .fetch_rsp_addr   (fetch_rsp_addr),
        .rob_cnt          (rob_cnt),
        .rsp_err          (rsp_err)
    );

    always #5 clk = ~clk;

    // Reference model: in-order list of live fetches, zombie set, sticky error.
    typedef struct {
        logic [31:0] addr;
        int          tid;
        bit          done;
        logic [63:0] data;
    } ment_t;

    ment_t       mq[$];
    bit          mz[D];
    bit          merr;
    int          mtail;
    int          pool[$];
    logic [31:0] log_addr[$];

    int n_checks = 0;
    int n_errs   = 0;

    logic        s_rdy, s_ivld, s_ovld, s_err, s_fire;
    logic [31:0] s_oaddr;
    logic [63:0] s_odata;
    logic [PW:0] s_cnt;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] dat(logic [31:0] a);
        return {32'hDA7A_5EED, a};
    endfunction

    task automatic model_reset();
        mq.delete();
        pool.delete();
        log_addr.delete();
        for (int i = 0; i < int'(D); i++) mz[i] = 1'b0;
        merr  = 1'b0;
        mtail = 0;
    endtask

    // One cycle: starts at negedge with inputs driven, compares, clocks, updates the model.
    task automatic step();
        int  tidx;
        int  hit_pos;
        int  rt;
        bit  e_full, e_rdy, e_ivld, e_ovld, drain;
        #1;
        tidx   = mtail % int'(D);
        e_full = (mq.size() == int'(D));
        e_rdy  = icache_req_rdy && !e_full && !mz[tidx] && !flush;
        e_ivld = fetch_req_vld && !e_full && !mz[tidx] && !flush;
        e_ovld = (mq.size() > 0) && mq[0].done && !flush;
        chk("req_rdy", 64'(fetch_req_rdy), 64'(e_rdy));
        chk("icache_vld", 64'(icache_req_vld), 64'(e_ivld));
        if (e_ivld) begin
            chk("pld_addr", 64'(icache_req_pld.addr), 64'(fetch_req_addr));
            chk("pld_txnid", 64'(icache_req_pld.txnid), 64'(tidx));
            chk("pld_opcode", 64'(icache_req_pld.opcode), 64'(UPSTREAM_OPCODE));
        end
        chk("rsp_vld", 64'(fetch_rsp_vld), 64'(e_ovld));
        if (e_ovld) begin
            chk("rsp_addr", 64'(fetch_rsp_addr), 64'(mq[0].addr));
            chk("rsp_data", 64'(fetch_rsp_data), mq[0].data);
        end
        chk("rob_cnt", 64'(rob_cnt), 64'(mq.size()));
        chk("rsp_err", 64'(rsp_err), 64'(merr));
        s_rdy   = fetch_req_rdy;
        s_ivld  = icache_req_vld;
        s_ovld  = fetch_rsp_vld;
        s_oaddr = fetch_rsp_addr;
        s_odata = fetch_rsp_data;
        s_cnt   = rob_cnt;
        s_err   = rsp_err;
        if (fetch_rsp_vld && fetch_rsp_rdy) log_addr.push_back(fetch_rsp_addr);
        s_fire = fetch_req_vld && e_rdy;
        drain  = e_ovld && fetch_rsp_rdy;
        @(posedge clk);
        hit_pos = -1;
        if (icache_rsp_vld) begin
            rt = int'(icache_rsp_txnid);
            for (int k = 0; k < mq.size(); k++)
                if (mq[k].tid == rt && !mq[k].done) hit_pos = k;
            if (hit_pos < 0) begin
                if (rt < int'(D) && mz[rt]) mz[rt] = 1'b0;
                else merr = 1'b1;
            end
        end
        if (flush) begin
            for (int k = 0; k < mq.size(); k++)
                if (!mq[k].done && k != hit_pos) mz[mq[k].tid] = 1'b1;
            mq.delete();
        end else begin
            if (hit_pos >= 0) begin
                mq[hit_pos].done = 1'b1;
                mq[hit_pos].data = icache_rsp_data;
            end
            if (drain) void'(mq.pop_front());
            if (s_fire) begin
                mq.push_back('{addr: fetch_req_addr, tid: tidx, done: 1'b0, data: 64'h0});
                pool.push_back(tidx);
                mtail = (mtail + 1) % int'(D);
            end
        end
        @(negedge clk);
        icache_rsp_vld = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic send_rsp(int t, logic [63:0] d);
        icache_rsp_vld   = 1'b1;
        icache_rsp_txnid = TW'(t);
        icache_rsp_data  = d;
        for (int k = 0; k < pool.size(); k++) begin
            if (pool[k] == t) begin
                pool.delete(k);
                break;
            end
        end
    endtask

    task automatic rand_rsp();
        int k;
        k = $urandom_range(pool.size() - 1, 0);
        send_rsp(pool[k], {$urandom, $urandom});
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        flush          = 1'b0;
        fetch_req_vld  = 1'b1;
        fetch_req_addr = 32'h0;
        icache_req_rdy = 1'b1;
        icache_rsp_vld = 1'b0;
        icache_rsp_data  = '0;
        icache_rsp_txnid = '0;
        fetch_rsp_rdy  = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_rdy", 64'(fetch_req_rdy), 64'h0);
        chk("rst_icache_vld", 64'(icache_req_vld), 64'h0);
        chk("rst_rsp_vld", 64'(fetch_rsp_vld), 64'h0);
        chk("rst_rob_cnt", 64'(rob_cnt), 64'h0);
        chk("rst_rsp_err", 64'(rsp_err), 64'h0);
        rst_n         = 1'b1;
        fetch_req_vld = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain_all(string nm);
        int c;
        c = 0;
        fetch_req_vld = 1'b0;
        fetch_rsp_rdy = 1'b1;
        while ((mq.size() > 0 || pool.size() > 0) && c < 400) begin
            if (pool.size() > 0 && $urandom_range(1, 0) == 1) rand_rsp();
            step();
            c++;
        end
        chk({nm, "_drain_timeout"}, 64'(mq.size() + pool.size()), 64'h0);
    endtask

    initial begin
        int issued;
        int c;

        // In-order return despite out-of-order icache responses.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fetch_req_vld  = 1'b1;
            fetch_req_addr = 32'h100 + 32'(i * 64);
            step();
        end
        fetch_req_vld = 1'b0;
        send_rsp(3, dat(32'h1C0)); step();
        send_rsp(1, dat(32'h140)); step();
        send_rsp(0, dat(32'h100)); step();
        chk("inord_no_bypass", 64'(s_ovld), 64'h0);
        send_rsp(2, dat(32'h180)); step();
        chk("inord_first_vld", 64'(s_ovld), 64'h1);
        chk("inord_first_addr", 64'(s_oaddr), 64'h100);
        chk("inord_first_data", s_odata, dat(32'h100));
        repeat (3) step();
        chk("inord_count", 64'(log_addr.size()), 64'h4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++)
            chk("inord_order", 64'(log_addr[i]), 64'h100 + 64'(i * 64));

        // Full: eight outstanding blocks new fetches until the head drains.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            fetch_req_vld  = 1'b1;
            fetch_req_addr = 32'h200 + 32'(i * 64);
            step();
        end
        step();
        chk("full_rdy", 64'(s_rdy), 64'h0);
        chk("full_cnt", 64'(s_cnt), 64'h8);
        fetch_req_vld = 1'b0;
        send_rsp(0, dat(32'h200)); step();
        step();
        chk("full_drain", 64'(s_ovld), 64'h1);
        step();
        chk("full_rdy_after", 64'(s_rdy), 64'h1);
        chk("full_cnt_after", 64'(s_cnt), 64'h7);
        drain_all("full");

        // Flush with in-flight fetches, then wrap the tail onto a zombie slot.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fetch_req_vld  = 1'b1;
            fetch_req_addr = 32'h400 + 32'(i * 64);
            step();
        end
        fetch_req_vld = 1'b0;
        flush = 1'b1;
        step();
        step();
        chk("flush_cnt", 64'(s_cnt), 64'h0);
        for (int i = 3; i < 8; i++) begin
            fetch_req_vld  = 1'b1;
            fetch_req_addr = 32'h400 + 32'(i * 64);
            step();
        end
        fetch_req_vld = 1'b0;
        for (int i = 3; i < 8; i++) begin
            send_rsp(i, dat(32'h400 + 32'(i * 64)));
            step();
        end
        c = 0;
        while (mq.size() > 0 && c < 20) begin step(); c++; end
        fetch_req_vld  = 1'b1;
        fetch_req_addr = 32'h500;
        repeat (3) begin
            step();
            chk("zombie_rdy", 64'(s_rdy), 64'h0);
            chk("zombie_icache_vld", 64'(s_ivld), 64'h0);
        end
        send_rsp(0, 64'hBAD0_BAD0_BAD0_BAD0);
        step();
        chk("zombie_rdy_rsp_cycle", 64'(s_rdy), 64'h0);
        step();
        chk("zombie_rdy_cleared", 64'(s_rdy), 64'h1);
        fetch_req_vld = 1'b0;
        step();
        chk("zombie_no_err", 64'(s_err), 64'h0);
        drain_all("flush");
        step();
        chk("zombie_no_err_end", 64'(s_err), 64'h0);

        // Stray response while idle sets the sticky error.
        do_reset();
        send_rsp(5, 64'h5);
        step();
        step();
        chk("err_set", 64'(s_err), 64'h1);
        fetch_req_vld  = 1'b1;
        fetch_req_addr = 32'h600;
        step();
        drain_all("err");
        step();
        chk("err_sticky", 64'(s_err), 64'h1);

        // Backpressure: head held stable while decode stalls.
        do_reset();
        fetch_rsp_rdy  = 1'b0;
        fetch_req_vld  = 1'b1;
        fetch_req_addr = 32'h300;
        step();
        fetch_req_vld = 1'b0;
        send_rsp(0, dat(32'h300));
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_vld", 64'(s_ovld), 64'h1);
            chk("bp_addr", 64'(s_oaddr), 64'h300);
            chk("bp_data", s_odata, dat(32'h300));
        end
        fetch_rsp_rdy = 1'b1;
        step();
        chk("bp_drain", 64'(s_ovld), 64'h1);
        step();
        chk("bp_after_vld", 64'(s_ovld), 64'h0);
        chk("bp_after_cnt", 64'(s_cnt), 64'h0);
        chk("bp_one_drain", 64'(log_addr.size()), 64'h1);

        // Wrap: twenty fetches through the pointers with random return order.
        do_reset();
        issued = 0;
        c = 0;
        while (log_addr.size() < 20 && c < 600) begin
            fetch_req_vld  = (issued < 20);
            fetch_req_addr = 32'h1000 + 32'(issued * 64);
            icache_req_rdy = 1'b1;
            fetch_rsp_rdy  = ($urandom_range(3, 0) != 0);
            if (pool.size() > 0 && $urandom_range(1, 0) == 1) rand_rsp();
            step();
            if (s_fire) issued++;
            c++;
        end
        chk("wrap_count", 64'(log_addr.size()), 64'd20);
        for (int i = 0; i < 20 && i < log_addr.size(); i++)
            chk("wrap_order", 64'(log_addr[i]), 64'h1000 + 64'(i * 64));

        // Randomized traffic including flushes coinciding with returns and drains.
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            fetch_req_vld  = ($urandom_range(9, 0) < 6);
            fetch_req_addr = $urandom & 32'hFFFF_FFC0;
            icache_req_rdy = ($urandom_range(9, 0) < 8);
            fetch_rsp_rdy  = ($urandom_range(9, 0) < 7);
            flush          = ($urandom_range(49, 0) == 0);
            if (pool.size() > 0 && $urandom_range(9, 0) < 4) rand_rsp();
            step();
        end
        drain_all("rand");

        // Reset mid-operation abandons slots; their late returns are errors.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            fetch_req_vld  = 1'b1;
            fetch_req_addr = 32'h700 + 32'(i * 64);
            step();
        end
        do_reset();
        send_rsp(0, 64'h7);
        step();
        step();
        chk("midrst_err", 64'(s_err), 64'h1);
        chk("midrst_cnt", 64'(s_cnt), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
